trigger_pulse_gen: RTL and testbench

Generates the outgoing trigger pulse that the digitizer drives to downstream instruments: the transmit-side counterpart of the comparator trigger receiver. An internal trigger event (the receiver's synchronized trigger output) or a host manual fire produces one pulse on `trig_out`. The pulse has a programmable delay and width, followed by a holdoff window. It sits in the ADC clock domain between the trigger receiver and the trigger-out pin buffer, and reports fired and missed event counts to the host register bank.

---
 rtl/trig_pkg.sv | 24 ++
 rtl/async_input_sync.sv | 25 ++
 rtl/trigger_pulse_gen.sv | 158 +++++++++++++++
 tb/tb_trigger_pulse_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared trigger-path definitions: one-hot state encodings for the transmit and
// receive FSMs, default counter widths and the counter saturation constant.
package trig_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WID_W_DEF = 8;

  // Wide enough to be sliced down to any supported counter width.
  localparam logic [63:0] CNT_SAT = '1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_DELAY   = 4'b0010,
    ST_PULSE   = 4'b0100,
    ST_HOLDOFF = 4'b1000
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'b001,
    RX_ARMED = 3'b010,
    RX_HOLD  = 3'b100
  } rx_state_t;

endpackage

// File: rtl/async_input_sync.sv
// Multi-flop synchronizer for slow asynchronous host controls into the ADC
// clock domain.
module async_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic module_reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/trigger_pulse_gen.sv
// Outgoing trigger pulse generator: delay, programmable width, holdoff, with
// fired/missed statistics. The DELAY stage exists only with TRIG_OUT_DELAY_EN.
module trigger_pulse_gen
  import trig_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WID_W = WID_W_DEF
) (
  input  logic             clk,
  input  logic             module_reset,
  input  logic             trig_in,
  input  logic             enable,
  input  logic             manual_fire,
  input  logic [CNT_W-1:0] delay_cycles,
  input  logic [WID_W-1:0] width_cycles,
  input  logic [CNT_W-1:0] holdoff_cycles,
  output logic             trig_out,
  output logic             busy,
  output logic [CNT_W-1:0] fired_count,
  output logic [CNT_W-1:0] missed_count
);

  localparam logic [CNT_W-1:0] MISS_MAX = CNT_SAT[CNT_W-1:0];

  logic             en_sync;
  logic             man_sync;
  logic             man_prev;
  logic             man_evt;
  logic             trig_prev;
  logic             evt;
  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WID_W-1:0] wcnt;
  logic [CNT_W-1:0] hold_lat;

  async_input_sync #(.STAGES(2), .RESET_VAL(1'b0)) u_en_sync (
    .clk          (clk),
    .module_reset (module_reset),
    .async_in     (enable),
    .sync_out     (en_sync)
  );

  async_input_sync #(.STAGES(2), .RESET_VAL(1'b0)) u_fire_sync (
    .clk          (clk),
    .module_reset (module_reset),
    .async_in     (manual_fire),
    .sync_out     (man_sync)
  );

`ifndef TRIG_OUT_DELAY_EN
  logic unused_delay;
  assign unused_delay = ^delay_cycles;
`endif

  // Edge-detect history clears to 1 so a level already high at reset release
  // is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset) begin
      trig_prev <= 1'b1;
      man_prev  <= 1'b1;
      man_evt   <= 1'b0;
      evt       <= 1'b0;
    end else begin
      trig_prev <= trig_in;
      man_prev  <= man_sync;
      man_evt   <= man_sync & ~man_prev;
      evt       <= (trig_in & ~trig_prev) | man_evt;
    end
  end

  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      wcnt         <= '0;
      hold_lat     <= '0;
      trig_out     <= 1'b0;
      busy         <= 1'b0;
      fired_count  <= '0;
      missed_count <= '0;
    end else begin
      if (evt && state != ST_IDLE && missed_count != MISS_MAX) begin
        missed_count <= missed_count + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (evt && en_sync) begin
            wcnt     <= (width_cycles == '0) ? '0 : width_cycles - 1'b1;
            hold_lat <= holdoff_cycles;
            busy     <= 1'b1;
`ifdef TRIG_OUT_DELAY_EN
            if (delay_cycles != '0) begin
              state <= ST_DELAY;
              cnt   <= delay_cycles - 1'b1;
            end else begin
              state       <= ST_PULSE;
              trig_out    <= 1'b1;
              fired_count <= fired_count + 1'b1;
            end
`else
            state       <= ST_PULSE;
            trig_out    <= 1'b1;
            fired_count <= fired_count + 1'b1;
`endif
          end
        end

`ifdef TRIG_OUT_DELAY_EN
        ST_DELAY: begin
          if (!en_sync) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state       <= ST_PULSE;
            trig_out    <= 1'b1;
            fired_count <= fired_count + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif

        // Enable is deliberately ignored here: a started pulse always completes.
        ST_PULSE: begin
          if (wcnt == '0) begin
            trig_out <= 1'b0;
            if (hold_lat != '0) begin
              state <= ST_HOLDOFF;
              cnt   <= hold_lat - 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end

        ST_HOLDOFF: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          trig_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed bench for trigger_pulse_gen; expected timing follows whether
// TRIG_OUT_DELAY_EN is defined. A 4-bit instance covers count saturation/wrap.
module tb_trigger_pulse_gen;

`ifdef TRIG_OUT_DELAY_EN
  localparam int DLY_ON = 1;
`else
  localparam int DLY_ON = 0;
`endif

  logic        clk;
  logic        module_reset;
  logic        trig_in;
  logic        enable;
  logic        manual_fire;
  logic [15:0] delay_cycles;
  logic [7:0]  width_cycles;
  logic [15:0] holdoff_cycles;
  logic        trig_out;
  logic        busy;
  logic [15:0] fired_count;
  logic [15:0] missed_count;

  logic        trig_small;
  logic        trig_out_small;
  logic        busy_small;
  logic [3:0]  fired_small;
  logic [3:0]  missed_small;

  int cyc = 0;
  int n0 = 0;
  int checks = 0;
  int failures = 0;
  int exp_fired = 0;
  int r = 0;

  trigger_pulse_gen dut (
    .clk            (clk),
    .module_reset   (module_reset),
    .trig_in        (trig_in),
    .enable         (enable),
    .manual_fire    (manual_fire),
    .delay_cycles   (delay_cycles),
    .width_cycles   (width_cycles),
    .holdoff_cycles (holdoff_cycles),
    .trig_out       (trig_out),
    .busy           (busy),
    .fired_count    (fired_count),
    .missed_count   (missed_count)
  );

  trigger_pulse_gen #(.CNT_W(4), .WID_W(8)) dut_small (
    .clk            (clk),
    .module_reset   (module_reset),
    .trig_in        (trig_small),
    .enable         (enable),
    .manual_fire    (manual_fire),
    .delay_cycles   (4'd0),
    .width_cycles   (8'd1),
    .holdoff_cycles (4'd15),
    .trig_out       (trig_out_small),
    .busy           (busy_small),
    .fired_count    (fired_small),
    .missed_count   (missed_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int de(input int d);
    return (DLY_ON != 0) ? d : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [7:0] w,
                               input logic [15:0] h);
    delay_cycles   = d;
    width_cycles   = w;
    holdoff_cycles = h;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one step after an edge; the next edge becomes event edge N.
  task automatic mark_event();
    n0 = cyc + 1;
  endtask

  task automatic at_edge(input int k);
    while (cyc < n0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    module_reset = 1'b1;
    trig_in      = 1'b0;
    trig_small   = 1'b0;
    enable       = 1'b0;
    manual_fire  = 1'b0;
    applyStimulus(16'd0, 8'd0, 16'd0);
    #12;
    checkOutput("rst_trig_out", {31'd0, trig_out}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_fired", {16'd0, fired_count}, 32'd0);
    checkOutput("rst_missed", {16'd0, missed_count}, 32'd0);
    @(negedge clk);
    module_reset = 1'b0;
    enable       = 1'b1;
    step(4);

    // Basic delayed pulse with holdoff; parameters changed mid-flight.
    applyStimulus(16'd5, 8'd3, 16'd10);
    trig_in = 1'b1;
    mark_event();
    at_edge(0);
    checkOutput("t1_busy_at_N", {31'd0, busy}, 32'd0);
    checkOutput("t1_out_at_N", {31'd0, trig_out}, 32'd0);
    at_edge(1);
    checkOutput("t1_busy_at_N1", {31'd0, busy}, 32'd1);
    trig_in = 1'b0;
    applyStimulus(16'd0, 8'd50, 16'd0);
    r = 1 + de(5);
    at_edge(r);
    checkOutput("t1_out_rise", {31'd0, trig_out}, 32'd1);
    at_edge(r + 2);
    checkOutput("t1_out_last", {31'd0, trig_out}, 32'd1);
    at_edge(r + 3);
    checkOutput("t1_out_fall", {31'd0, trig_out}, 32'd0);
    at_edge(r + 12);
    checkOutput("t1_busy_holdoff", {31'd0, busy}, 32'd1);
    at_edge(r + 13);
    checkOutput("t1_busy_fall", {31'd0, busy}, 32'd0);
    exp_fired = 1;
    checkOutput("t1_fired", {16'd0, fired_count}, exp_fired);

    // Zero width/holdoff: 1-cycle pulse, back-to-back event accepted.
    step(3);
    applyStimulus(16'd0, 8'd0, 16'd0);
    trig_in = 1'b1;
    mark_event();
    at_edge(0);
    trig_in = 1'b0;
    at_edge(1);
    checkOutput("t2_pulse1", {31'd0, trig_out}, 32'd1);
    trig_in = 1'b1;
    at_edge(2);
    checkOutput("t2_gap", {31'd0, trig_out}, 32'd0);
    checkOutput("t2_gap_busy", {31'd0, busy}, 32'd0);
    trig_in = 1'b0;
    at_edge(3);
    checkOutput("t2_pulse2", {31'd0, trig_out}, 32'd1);
    at_edge(4);
    exp_fired = exp_fired + 2;
    checkOutput("t2_fired", {16'd0, fired_count}, exp_fired);
    checkOutput("t2_missed", {16'd0, missed_count}, 32'd0);

    // Second event inside the busy window is counted as missed.
    step(3);
    applyStimulus(16'd4, 8'd2, 16'd20);
    trig_in = 1'b1;
    mark_event();
    at_edge(1);
    trig_in = 1'b0;
    at_edge(10);
    trig_in = 1'b1;
    at_edge(11);
    trig_in = 1'b0;
    at_edge(1 + de(4) + 2 + 20 + 1);
    exp_fired = exp_fired + 1;
    checkOutput("t3_fired", {16'd0, fired_count}, exp_fired);
    checkOutput("t3_missed", {16'd0, missed_count}, 32'd1);
    checkOutput("t3_busy", {31'd0, busy}, 32'd0);

    // Enable dropped during the delay aborts the pulse (no delay: pulse done).
    step(2);
    applyStimulus(16'd100, 8'd1, 16'd0);
    trig_in = 1'b1;
    mark_event();
    at_edge(1);
    trig_in = 1'b0;
    checkOutput("t4_out_N1", {31'd0, trig_out}, (DLY_ON != 0) ? 32'd0 : 32'd1);
    at_edge(5);
    enable = 1'b0;
    at_edge(12);
    checkOutput("t4_busy_abort", {31'd0, busy}, 32'd0);
    exp_fired = exp_fired + ((DLY_ON != 0) ? 0 : 1);
    checkOutput("t4_fired", {16'd0, fired_count}, exp_fired);
    enable = 1'b1;
    step(4);

    // Enable dropped during the pulse does not truncate it.
    applyStimulus(16'd0, 8'd8, 16'd0);
    trig_in = 1'b1;
    mark_event();
    at_edge(1);
    trig_in = 1'b0;
    enable  = 1'b0;
    checkOutput("t5_out_start", {31'd0, trig_out}, 32'd1);
    at_edge(8);
    checkOutput("t5_out_end", {31'd0, trig_out}, 32'd1);
    at_edge(9);
    checkOutput("t5_out_fall", {31'd0, trig_out}, 32'd0);
    exp_fired = exp_fired + 1;
    checkOutput("t5_fired", {16'd0, fired_count}, exp_fired);
    enable = 1'b1;
    step(4);

    // Manual fire: 3 cycles to event edge N, then the usual delay.
    applyStimulus(16'd3, 8'd2, 16'd0);
    manual_fire = 1'b1;
    mark_event();
    at_edge(2);
    manual_fire = 1'b0;
    r = 4 + de(3);
    at_edge(r - 1);
    checkOutput("t6_out_before", {31'd0, trig_out}, 32'd0);
    at_edge(r);
    checkOutput("t6_out_rise", {31'd0, trig_out}, 32'd1);
    at_edge(r + 1);
    checkOutput("t6_out_high", {31'd0, trig_out}, 32'd1);
    at_edge(r + 2);
    checkOutput("t6_out_fall", {31'd0, trig_out}, 32'd0);
    exp_fired = exp_fired + 1;
    checkOutput("t6_fired", {16'd0, fired_count}, exp_fired);

    // Reset mid-pulse drops trig_out at once; trig_in held high through release.
    step(20);
    applyStimulus(16'd0, 8'd8, 16'd0);
    trig_in = 1'b1;
    mark_event();
    at_edge(2);
    checkOutput("t7_out_pre", {31'd0, trig_out}, 32'd1);
    #2;
    module_reset = 1'b1;
    #1;
    checkOutput("t7_out_async", {31'd0, trig_out}, 32'd0);
    checkOutput("t7_fired_rst", {16'd0, fired_count}, 32'd0);
    checkOutput("t7_missed_rst", {16'd0, missed_count}, 32'd0);
    #3;
    module_reset = 1'b0;
    step(10);
    checkOutput("t7_no_event_busy", {31'd0, busy}, 32'd0);
    checkOutput("t7_no_event_fired", {16'd0, fired_count}, 32'd0);

    // 4-bit instance: 8 misses per round (last on the return-to-idle edge),
    // then one accepted event; missed saturates at 15.
    for (int round = 1; round <= 3; round++) begin
      trig_small = 1'b1;
      step(1);
      trig_small = 1'b0;
      step(1);
      for (int k = 0; k < 9; k++) begin
        trig_small = 1'b1;
        step(1);
        trig_small = 1'b0;
        step(1);
      end
      step(20);
      checkOutput($sformatf("sat_missed_r%0d", round), {28'd0, missed_small},
                  (8 * round > 15) ? 32'd15 : 8 * round);
      checkOutput($sformatf("sat_fired_r%0d", round), {28'd0, fired_small}, 2 * round);
    end

    // Ten more accepted events take the 4-bit fired count from 6 through 15 to 0.
    for (int k = 0; k < 10; k++) begin
      trig_small = 1'b1;
      step(1);
      trig_small = 1'b0;
      step(18);
    end
    checkOutput("wrap_fired", {28'd0, fired_small}, 32'd0);
    checkOutput("wrap_missed", {28'd0, missed_small}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
